// File: rtl/multiply_1.sv
// Word-serial GF(2) multiply by (1 + x): out = in ^ (in << 1), one W-bit word per
// clock, least-significant word first, with a one-bit carry between words.
module multiply_1 #(
    parameter int N = 4480,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] in,
    output logic [N:0]   out,
    output logic         busy,
    output logic         done
);

    localparam int WORDS = N / W;
    localparam int CW    = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    if (N % W != 0) begin : g_bad_width
        $error("multiply_1: N must be an integer multiple of W");
    end

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [N-1:0]  store;
    logic [W-1:0]  word;
    logic [W-1:0]  res;

    assign word = store[W-1:0];
    assign res  = word ^ {word[W-2:0], carry};
    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (cnt == LAST) state_next = FLUSH;
            FLUSH:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            carry <= 1'b0;
            cnt   <= '0;
            store <= '0;
            out   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        store <= in;
                        carry <= 1'b0;
                        cnt   <= '0;
                        out   <= '0;
                    end
                end
                RUN: begin
                    carry <= word[W-1];
                    store <= store >> W;
                    cnt   <= cnt + CW'(1);
                    // Words enter at the top; after the last one they sit in out[N:1].
                    out   <= {res, out[N:W]};
                end
                FLUSH: begin
                    out <= {carry, out[N:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_1.sv
// Directed and randomised checks of multiply_1 at its default size: latency,
// handshake, reset behaviour and the golden in ^ (in << 1) product.
module tb_multiply_1;

    localparam int N = 4480;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] in;
    logic [N:0]   out;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_fail;

    multiply_1 #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in(in),
        .out(out), .busy(busy), .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_diff(input logic [N:0] a, input logic [N:0] b);
        for (int i = 0; i <= N; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic logic [N:0] golden(input logic [N-1:0] v);
        return {1'b0, v} ^ {v, 1'b0};
    endfunction

    // divide-by-(1 + x): prefix XOR undoes the multiply
    function automatic logic [N:0] divide_1px(input logic [N:0] p);
        logic [N:0] q;
        q[0] = p[0];
        for (int i = 1; i <= N; i++) q[i] = p[i] ^ q[i-1];
        return q;
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // driver tasks: entered and left just after a falling edge
    task automatic start_op(input logic [N-1:0] v);
        start = 1'b1;
        in    = v;
        @(negedge clk);
        start = 1'b0;
        in    = rand_vec();
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done !== 1'b1 && busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_low=%h busy=%b done=%b, required 0/0/0",
                     out[63:0], busy, done);
        end
    endtask

    task automatic test_single();
        int cyc, bc;
        logic [N:0] exp;
        exp = '0; exp[0] = 1'b1; exp[1] = 1'b1;
        start_op(N'(1));
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc !== 141) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, required 141", cyc);
        end
        n_cmp++;
        if (bc !== 141) begin
            n_fail++;
            $display("FAIL single_busy_cycles: got %0d, required 141", bc);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_at_done: got %b, required 0", busy);
        end
        n_cmp++;
        if (out !== exp) begin
            n_fail++;
            $display("FAIL single_out: got low %h, required low %h (first diff bit %0d)",
                     out[63:0], exp[63:0], first_diff(out, exp));
        end
    endtask

    task automatic test_directed();
        int cyc, bc;
        logic [N-1:0] v;
        logic [N:0]   exp;
        // bit 31 only: word-boundary carry
        v = '0; v[31] = 1'b1;
        exp = '0; exp[31] = 1'b1; exp[32] = 1'b1;
        start_op(v);
        wait_done(cyc, bc);
        n_cmp++;
        if (out !== exp || cyc !== 141) begin
            n_fail++;
            $display("FAIL bit31_out: got low %h lat %0d, required low %h lat 141 (diff bit %0d)",
                     out[63:0], cyc, exp[63:0], first_diff(out, exp));
        end
        // bit N-1 only: top-bit flush
        v = '0; v[N-1] = 1'b1;
        exp = '0; exp[N-1] = 1'b1; exp[N] = 1'b1;
        start_op(v);
        wait_done(cyc, bc);
        n_cmp++;
        if (out !== exp || cyc !== 141) begin
            n_fail++;
            $display("FAIL topbit_out: got top %h lat %0d, required top %h lat 141 (diff bit %0d)",
                     out[N:N-7], cyc, exp[N:N-7], first_diff(out, exp));
        end
        // all ones: interior coefficients cancel
        v = '1;
        exp = '0; exp[0] = 1'b1; exp[N] = 1'b1;
        start_op(v);
        wait_done(cyc, bc);
        n_cmp++;
        if (out !== exp || cyc !== 141) begin
            n_fail++;
            $display("FAIL allones_out: got low %h top %b lat %0d, required low %h top 1 (diff bit %0d)",
                     out[63:0], out[N], cyc, exp[63:0], first_diff(out, exp));
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        int bad_out, bad_inv, bad_lat, bad_hs;
        logic [N-1:0] v;
        logic [N:0]   exp_q[$];
        logic [N:0]   exp;
        bad_out = 0; bad_inv = 0; bad_lat = 0; bad_hs = 0;
        for (int op = 0; op < 100; op++) begin
            v = rand_vec();
            exp_q.push_back(golden(v));
            start_op(v);
            if (done !== 1'b0 || busy !== 1'b1) bad_hs++;
            wait_done(cyc, bc);
            exp = exp_q.pop_front();
            if (cyc !== 141) bad_lat++;
            if (out !== exp) begin
                bad_out++;
                if (bad_out == 1)
                    $display("FAIL b2b_out: op %0d got low %h, required low %h (diff bit %0d)",
                             op, out[63:0], exp[63:0], first_diff(out, exp));
            end
            if (divide_1px(out) !== {1'b0, v}) bad_inv++;
        end
        n_cmp++;
        if (bad_out != 0) begin
            n_fail++;
            $display("FAIL b2b_results: %0d wrong products, required 0", bad_out);
        end
        n_cmp++;
        if (bad_inv != 0) begin
            n_fail++;
            $display("FAIL b2b_inverse: %0d results not undone by divide, required 0", bad_inv);
        end
        n_cmp++;
        if (bad_lat != 0) begin
            n_fail++;
            $display("FAIL b2b_latency: %0d ops not at 141 cycles, required 0", bad_lat);
        end
        n_cmp++;
        if (bad_hs != 0) begin
            n_fail++;
            $display("FAIL b2b_accept: %0d accepts without done=0 busy=1, required 0", bad_hs);
        end
    endtask

    task automatic test_abuse();
        int cyc, bc, bad;
        logic [N-1:0] v1;
        logic [N:0]   exp;
        v1  = rand_vec();
        exp = golden(v1);
        start_op(v1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        in    = ~v1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        n_cmp++;
        if (cyc !== 136) begin
            n_fail++;
            $display("FAIL abuse_latency: got %0d cycles after E5, required 136", cyc);
        end
        n_cmp++;
        if (out !== exp) begin
            n_fail++;
            $display("FAIL abuse_out: got low %h, required low %h (diff bit %0d)",
                     out[63:0], exp[63:0], first_diff(out, exp));
        end
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done !== 1'b1 || busy !== 1'b0 || out !== exp) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abuse_hold: %0d cycles left DONE or changed out, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bc, bad;
        logic [N:0] exp;
        start_op(rand_vec());
        repeat (69) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: out_low=%h busy=%b done=%b, required 0/0/0",
                     out[63:0], busy, done);
        end
        exp = '0; exp[1:0] = 2'b11;
        start_op(N'(1));
        wait_done(cyc, bc);
        n_cmp++;
        if (out !== exp || cyc !== 141) begin
            n_fail++;
            $display("FAIL midrst_restart: got low %h lat %0d, required 3 lat 141",
                     out[63:0], cyc);
        end
        rst = 1'b1; start = 1'b1; in = '1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || out !== '0) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_and_start: %0d samples not idle, required 0", bad);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        in     = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_directed();
        test_back_to_back();
        test_abuse();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
